// File: rtl/flopr_pipe.sv
// Elastic DEPTH-stage pipeline register with valid/ready handshake, bubble
// collapsing, synchronous flush and occupancy count. Optional input skid: FLOPR_PIPE_SKID_EN.
module flopr_pipe #(
  parameter int unsigned       WIDTH     = 8,
  parameter int unsigned       DEPTH     = 2,
  parameter logic [WIDTH-1:0]  RESET_VAL = '0
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        flush,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [WIDTH-1:0]            in_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [WIDTH-1:0]            out_data,
  output logic [$clog2(DEPTH+2)-1:0]  count
);

  localparam int unsigned CW = $clog2(DEPTH+2);

  logic             r_valid [DEPTH];
  logic [WIDTH-1:0] r_data  [DEPTH];
  logic [CW-1:0]    r_count;

  logic [DEPTH-1:0] w_adv;
  logic             w_src_valid [DEPTH];
  logic [WIDTH-1:0] w_src_data  [DEPTH];
  logic             w_full;
  logic             w_in_xfer;
  logic             w_out_xfer;

  // Ready chain flattened: stage i advances if out_ready or any stage at/after i is empty.
  always_comb begin
    w_full = 1'b1;
    w_adv  = '0;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      w_full               = w_full & r_valid[DEPTH-1-k];
      w_adv[DEPTH-1-k]     = out_ready | ~w_full;
    end
  end

  assign out_valid  = r_valid[DEPTH-1] & ~flush;
  assign out_data   = r_data[DEPTH-1];
  assign w_out_xfer = out_valid & out_ready;
  assign w_in_xfer  = in_valid & in_ready;
  assign count      = r_count;

`ifdef FLOPR_PIPE_SKID_EN
  logic             r_skid_valid;
  logic [WIDTH-1:0] r_skid_data;

  assign in_ready = ~r_skid_valid & ~flush;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_skid_valid <= 1'b0;
      r_skid_data  <= RESET_VAL;
    end else if (flush) begin
      r_skid_valid <= 1'b0;
    end else if (r_skid_valid) begin
      if (w_adv[0]) r_skid_valid <= 1'b0;
    end else if (w_in_xfer && !w_adv[0]) begin
      r_skid_valid <= 1'b1;
      r_skid_data  <= in_data;
    end
  end
`else
  assign in_ready = w_adv[0] & ~flush;
`endif

  always_comb begin
`ifdef FLOPR_PIPE_SKID_EN
    w_src_valid[0] = r_skid_valid | in_valid;
    w_src_data[0]  = r_skid_valid ? r_skid_data : in_data;
`else
    w_src_valid[0] = in_valid;
    w_src_data[0]  = in_data;
`endif
    for (int unsigned i = 1; i < DEPTH; i++) begin
      w_src_valid[i] = r_valid[i-1];
      w_src_data[i]  = r_data[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_valid[i] <= 1'b0;
        r_data[i]  <= RESET_VAL;
      end
      r_count <= '0;
    end else if (flush) begin
      for (int unsigned i = 0; i < DEPTH; i++) r_valid[i] <= 1'b0;
      r_count <= '0;
    end else begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (w_adv[i]) begin
          r_valid[i] <= w_src_valid[i];
          if (w_src_valid[i]) r_data[i] <= w_src_data[i];
        end
      end
      case ({w_in_xfer, w_out_xfer})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: tb/tb_flopr_pipe.sv
// Bench for flopr_pipe: queue-of-entries position model checked every cycle,
// plus directed scenarios with literal expectations and a randomized soak.
module tb_flopr_pipe;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned DEPTH = 3;
  localparam logic [7:0]  RV    = 8'hA5;
`ifdef FLOPR_PIPE_SKID_EN
  localparam int CAP = DEPTH + 1;
`else
  localparam int CAP = DEPTH;
`endif

  logic       clk;
  logic       reset;
  logic       flush;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic [$clog2(DEPTH+2)-1:0] count;

  flopr_pipe #(.WIDTH(WIDTH), .DEPTH(DEPTH), .RESET_VAL(RV)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .count(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: queue of in-flight entries (oldest first) with position -1 (skid) .. DEPTH-1.
  int         qpos[$];
  logic [7:0] qdat[$];
  int         np[$];
  logic [7:0] tail;
  bit         model_on = 0;

  always @(negedge clk) begin
    int  n, prev, k, pp;
    bit  pop, e_ov, e_ir, has_skid;
    logic [7:0] nt;
    if (!model_on) begin
      if (!reset) begin
        qpos.delete(); qdat.delete(); tail = RV; model_on = 1;
      end
    end else begin
      e_ov = !flush && qpos.size() > 0 && qpos[0] == DEPTH-1;
      pop  = e_ov && out_ready;
      prev = DEPTH;
      nt   = tail;
      np.delete();
      has_skid = 0;
      for (k = 0; k < qpos.size(); k++) begin
        if (qpos[k] < 0) has_skid = 1;
        if (!(k == 0 && pop)) begin
          n = (qpos[k] + 1 < prev - 1) ? qpos[k] + 1 : prev - 1;
          if (n == DEPTH-1 && qpos[k] != DEPTH-1) nt = qdat[k];
          np.push_back(n);
          prev = n;
        end
      end
`ifdef FLOPR_PIPE_SKID_EN
      e_ir = !flush && !has_skid;
`else
      e_ir = !flush && prev >= 1;
`endif
      chk("out_valid", 32'(out_valid), 32'(e_ov));
      chk("in_ready",  32'(in_ready),  32'(e_ir));
      chk("count",     32'(count),     32'(qpos.size()));
      chk("out_data",  32'(out_data),  32'(tail));
      if (!reset) begin
        qpos.delete(); qdat.delete(); tail = RV;
      end else if (flush) begin
        qpos.delete(); qdat.delete();
      end else begin
        if (pop) void'(qdat.pop_front());
        qpos = np;
        tail = nt;
        if (in_valid && e_ir) begin
          pp = (prev - 1 < 0) ? prev - 1 : 0;
          qpos.push_back(pp);
          qdat.push_back(in_data);
          if (pp == DEPTH-1) tail = in_data;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int nxt, expv;
    reset = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
    tick(); tick();
    reset = 1'b1;
    #3;
    chk("rst_count", 32'(count), 0);
    chk("rst_ovalid", 32'(out_valid), 0);
    chk("rst_odata", 32'(out_data), 32'h0A5);
    chk("rst_iready", 32'(in_ready), 1);
    tick();

    // Unstalled stream: latency DEPTH, steady occupancy DEPTH
    out_ready = 1'b1;
    for (int k = 1; k <= 13; k++) begin
      in_valid = (k <= 10);
      in_data  = 8'(k);
      #3;
      if (k == 3) chk("lat_not_yet", 32'(out_valid), 0);
      if (k == 4) begin
        chk("lat_first", 32'(out_data), 1);
        chk("lat_ovalid", 32'(out_valid), 1);
        chk("steady_cnt", 32'(count), 3);
      end
      if (k == 13) chk("last_val", 32'(out_data), 10);
      tick();
    end
    in_valid = 1'b0;

    // Backpressure fill
    out_ready = 1'b0;
    nxt = 1;
    for (int k = 0; k < 6; k++) begin
      in_valid = (nxt <= 4);
      in_data  = 8'(nxt);
      #3;
      if (in_valid && in_ready) nxt++;
      tick();
    end
    in_valid = 1'b0;
    #3;
    chk("bp_accepts", 32'(nxt - 1), 32'(CAP));
    chk("bp_count", 32'(count), 32'(CAP));
    chk("bp_iready", 32'(in_ready), 0);
    tick();
    out_ready = 1'b1;
    expv = 1;
    for (int k = 0; k < 10; k++) begin
      #3;
      if (out_valid) begin
        chk("bp_order", 32'(out_data), 32'(expv));
        expv++;
      end
      tick();
    end
    chk("bp_drained", 32'(expv - 1), 32'(CAP));
    #3;
    chk("bp_cnt0", 32'(count), 0);
    tick();

    // Bubble collapse
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 8'h3C; tick();
    in_valid = 1'b0; tick(); tick();
    in_valid = 1'b1; in_data = 8'hC3;
    #3;
    chk("bub_iready_b", 32'(in_ready), 1);
    tick();
    in_valid = 1'b0; tick();
    out_ready = 1'b1;
    #3;
    chk("bub_count", 32'(count), 2);
    chk("bub_iready", 32'(in_ready), 1);
    chk("bub_first", 32'({out_valid, out_data}), 32'h13C);
    tick();
    #3;
    chk("bub_second", 32'({out_valid, out_data}), 32'h1C3);
    tick(); tick();

    // Flush with full pipe and a flush-cycle input
    out_ready = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      in_valid = 1'b1; in_data = 8'(k * 8'h11); tick();
    end
    flush = 1'b1; in_valid = 1'b1; in_data = 8'h99; out_ready = 1'b1;
    #3;
    chk("fl_ovalid", 32'(out_valid), 0);
    chk("fl_iready", 32'(in_ready), 0);
    tick();
    flush = 1'b0; in_valid = 1'b0;
    #3;
    chk("fl_count", 32'(count), 0);
    chk("fl_ovalid_after", 32'(out_valid), 0);
    for (int k = 0; k < 5; k++) tick();

    // Reset mid-stream
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 8'h44; tick();
    in_data = 8'h55; tick();
    in_valid = 1'b0;
    #3;
    chk("mr_count2", 32'(count), 2);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    #3;
    chk("mr_count0", 32'(count), 0);
    chk("mr_ovalid", 32'(out_valid), 0);
    chk("mr_odata", 32'(out_data), 32'h0A5);
    tick();

    // Randomized soak
    for (int k = 0; k < 3000; k++) begin
      in_valid  = ($urandom_range(3) != 0);
      out_ready = ($urandom_range(2) != 0);
      in_data   = 8'($urandom);
      flush     = ($urandom_range(40) == 0);
      reset     = ($urandom_range(200) != 0);
      tick();
    end
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    for (int k = 0; k < 8; k++) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
